// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one fixed-latency pipelined multiplier among NREQ requesters.
// Define MULT_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module mult_sched #(
  parameter int SIZE     = 16,
  parameter int NREQ     = 4,
  parameter int MULT_LAT = 3,
  parameter int IDW      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*SIZE-1:0]   req_a,
  input  logic [NREQ*SIZE-1:0]   req_b,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   pause,
  output logic [SIZE-1:0]        mult_a,
  output logic [SIZE-1:0]        mult_b,
  input  logic [2*SIZE-1:0]      mult_pdt,
  output logic                   res_valid,
  output logic [IDW-1:0]         res_id,
  output logic [2*SIZE-1:0]      res_pdt,
  output logic                   busy,
  output logic                   idle
);

  localparam int CNTW = $clog2(MULT_LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [IDW-1:0]        rr_q;
  logic [MULT_LAT-1:0]   tag_vld_q;
  logic [IDW-1:0]        tag_id_q [MULT_LAT];
  logic [CNTW-1:0]       cnt_q, cnt_d;

  logic [SIZE-1:0]       a_arr [NREQ];
  logic [SIZE-1:0]       b_arr [NREQ];
  logic                  found;
  logic [IDW-1:0]        gnt_id;
  logic [IDW-1:0]        scan_id;
  int                    scan_idx;
  logic                  grant_en;
  logic                  xfer;
  logic                  retire;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*SIZE +: SIZE];
    assign b_arr[gi] = req_b[gi*SIZE +: SIZE];
  end

`ifdef MULT_SCHED_FIXED_PRIO_EN
  assign rr_q = '0;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= '0;
    end else if (xfer) begin
      rr_q <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
    end
  end
`endif

  // Search upward from the pointer, wrapping, for the first valid requester.
  always_comb begin
    found    = 1'b0;
    gnt_id   = '0;
    scan_id  = '0;
    scan_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = int'(rr_q) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      scan_id = IDW'(scan_idx);
      if (!found && req_valid[scan_id]) begin
        found  = 1'b1;
        gnt_id = scan_id;
      end
    end
  end

  assign grant_en  = !rst && !pause && (state_q != DRAIN);
  assign xfer      = grant_en && found;
  assign req_ready = xfer ? (NREQ'(1) << gnt_id) : '0;
  assign mult_a    = xfer ? a_arr[gnt_id] : '0;
  assign mult_b    = xfer ? b_arr[gnt_id] : '0;

  assign retire    = tag_vld_q[MULT_LAT-1];
  assign res_valid = retire;
  assign res_id    = tag_id_q[MULT_LAT-1];
  assign res_pdt   = mult_pdt;

  // busy and the drain decision look at the count after this cycle's issue/retire.
  always_comb begin
    cnt_d = cnt_q;
    if (rst) begin
      cnt_d = '0;
    end else if (xfer && !retire) begin
      cnt_d = cnt_q + CNTW'(1);
    end else if (!xfer && retire) begin
      cnt_d = cnt_q - CNTW'(1);
    end
  end

  assign busy = (cnt_d != '0);
  assign idle = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req_valid && !pause) state_d = RUN;
      RUN: begin
        if (pause) state_d = DRAIN;
        else if (!(|req_valid) && cnt_d == '0) state_d = IDLE;
      end
      DRAIN: begin
        if (cnt_d == '0) state_d = IDLE;
        else if (!pause) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tag_vld_q <= '0;
      for (int i = 0; i < MULT_LAT; i++) tag_id_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tag_vld_q[0] <= xfer;
      tag_id_q[0]  <= xfer ? gnt_id : '0;
      for (int i = 1; i < MULT_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
    end
  end

endmodule
